// File: rtl/output_port_arbiter_pkg.sv
// Shared types and constants for the per-output-port arbiter of the router crossbar.
package output_port_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned DIR_LOCAL = 0;
  localparam int unsigned DIR_NORTH = 1;
  localparam int unsigned DIR_EAST  = 2;
  localparam int unsigned DIR_SOUTH = 3;
  localparam int unsigned DIR_WEST  = 4;
  localparam int unsigned DIR_UP    = 5;
  localparam int unsigned PORT_NUM  = 6;

  // Downstream input queue depth; one credit per slot.
  localparam int unsigned INPUT_Q_SIZE = 5;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/output_port_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester at or above rr_ptr, wrapping.
module rr_priority_picker #(
  parameter int unsigned M_IN  = 6,
  parameter int unsigned SEL_W = 3
) (
  input  logic [M_IN-1:0]  req,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic [M_IN-1:0]  winner,
  output logic [SEL_W-1:0] winner_idx,
  output logic             any_req
);

  localparam int unsigned DW = 2 * M_IN;

  logic [DW-1:0] dbl_req;
  logic [DW-1:0] mask;
  logic [DW-1:0] masked;
  logic          found;

  // Lower copy masked below rr_ptr, upper copy unmasked provides the wrap.
  always_comb begin
    dbl_req    = {req, req};
    mask       = {DW{1'b1}} << rr_ptr;
    masked     = dbl_req & mask;
    found      = 1'b0;
    winner_idx = '0;
    for (int i = 0; i < DW; i++) begin
      if (!found && masked[i]) begin
        found      = 1'b1;
        winner_idx = (i < M_IN) ? SEL_W'(i) : SEL_W'(i - M_IN);
      end
    end
    winner = '0;
    for (int j = 0; j < M_IN; j++) begin
      winner[j] = found && (winner_idx == SEL_W'(j));
    end
    any_req = found;
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port controller: packet-atomic round-robin grant plus downstream credit tracking.
module output_port_arbiter
  import output_port_arbiter_pkg::*;
#(
  parameter int unsigned M_IN       = PORT_NUM,
  parameter int unsigned CREDIT_MAX = INPUT_Q_SIZE,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned CRED_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [M_IN-1:0]   req,
  input  logic [M_IN-1:0]   req_tail,
  input  logic              credit_in,
  output logic [M_IN-1:0]   grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              out_valid,
  output logic [CRED_W-1:0] credits,
  output logic              credit_err
);

  arb_state_e       state, next_state;
  logic [SEL_W-1:0] rr_ptr, next_rr_ptr;
  logic [SEL_W-1:0] owner, next_owner;
  logic [M_IN-1:0]  win_onehot;
  logic [SEL_W-1:0] win_idx;
  logic             win_any;
  logic             can_send;
  logic             fire;

  rr_priority_picker #(
    .M_IN  (M_IN),
    .SEL_W (SEL_W)
  ) u_picker (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .winner     (win_onehot),
    .winner_idx (win_idx),
    .any_req    (win_any)
  );

  // A credit returned this cycle only becomes usable next cycle.
  assign can_send = (credits != '0);

  function automatic logic [SEL_W-1:0] next_port(input logic [SEL_W-1:0] idx);
    return (idx == SEL_W'(M_IN - 1)) ? '0 : idx + SEL_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= next_state;
      rr_ptr <= next_rr_ptr;
      owner  <= next_owner;
    end
  end

  always_comb begin
    next_state  = state;
    next_rr_ptr = rr_ptr;
    next_owner  = owner;
    grant       = '0;
    unique case (state)
      IDLE: begin
        if (can_send && win_any) begin
          grant = win_onehot;
          if (req_tail[win_idx]) begin
            next_rr_ptr = next_port(win_idx);
          end else begin
            next_state = LOCKED;
            next_owner = win_idx;
          end
        end
      end
      LOCKED: begin
        // Lock is held through owner bubbles; nobody else may cut in mid-packet.
        if (req[owner] && can_send) begin
          for (int j = 0; j < M_IN; j++) begin
            grant[j] = (owner == SEL_W'(j));
          end
          if (req_tail[owner]) begin
            next_state  = IDLE;
            next_rr_ptr = next_port(owner);
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    grant_idx = '0;
    for (int j = 0; j < M_IN; j++) begin
      if (grant[j]) grant_idx = SEL_W'(j);
    end
  end

  assign fire      = |grant;
  assign out_valid = fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      credits    <= CRED_W'(CREDIT_MAX);
      credit_err <= 1'b0;
    end else begin
      unique case ({fire, credit_in})
        2'b10: credits <= credits - CRED_W'(1);
        2'b01: begin
          if (credits == CRED_W'(CREDIT_MAX)) credit_err <= 1'b1;
          else                                credits    <= credits + CRED_W'(1);
        end
        default: credits <= credits;
      endcase
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: round-robin, packet lock, credit flow, reset.
module tb_output_port_arbiter;

  logic       clk;
  logic       rst;
  logic [5:0] req;
  logic [5:0] req_tail;
  logic       credit_in;
  logic [5:0] grant;
  logic [2:0] grant_idx;
  logic       out_valid;
  logic [2:0] credits;
  logic       credit_err;

  int checks;
  int failures;

  output_port_arbiter #(
    .M_IN       (6),
    .CREDIT_MAX (5),
    .SEL_W      (3),
    .CRED_W     (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_tail   (req_tail),
    .credit_in  (credit_in),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .out_valid  (out_valid),
    .credits    (credits),
    .credit_err (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+1; outputs are sampled at posedge+5.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_tail = '0; credit_in = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_tail = '0; credit_in = 1'b0;
    next_cycle();
    #4;
    checks++; if (grant !== 6'b0) begin failures++; $display("FAIL reset_grant got=%b exp=%b", grant, 6'b0); end
    checks++; if (grant_idx !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", grant_idx); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (credits !== 3'd5) begin failures++; $display("FAIL reset_credits got=%0d exp=5", credits); end
    checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", credit_err); end
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [5:0] eg [0:2];
    logic [2:0] ei [0:2];
    logic [2:0] ec [0:2];
    eg = '{6'b000001, 6'b000100, 6'b000001};
    ei = '{3'd0, 3'd2, 3'd0};
    ec = '{3'd5, 3'd4, 3'd3};
    do_reset();
    req = 6'b000101; req_tail = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      #4;
      checks++; if (grant !== eg[i]) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, grant, eg[i]); end
      checks++; if (grant_idx !== ei[i]) begin failures++; $display("FAIL rr_idx[%0d] got=%0d exp=%0d", i, grant_idx, ei[i]); end
      checks++; if (credits !== ec[i]) begin failures++; $display("FAIL rr_credits[%0d] got=%0d exp=%0d", i, credits, ec[i]); end
      next_cycle();
    end
    req = '0;
    #4;
    checks++; if (credits !== 3'd2) begin failures++; $display("FAIL rr_credits_end got=%0d exp=2", credits); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_idle_valid got=%b exp=0", out_valid); end
    next_cycle();
  endtask

  task automatic test_packet_lock();
    logic [5:0] et [0:3];
    logic [5:0] eg [0:3];
    logic [2:0] ec [0:3];
    et = '{6'b000000, 6'b000000, 6'b001000, 6'b000000};
    eg = '{6'b001000, 6'b001000, 6'b001000, 6'b010000};
    ec = '{3'd4, 3'd3, 3'd2, 3'd1};
    do_reset();
    req = 6'b000100; req_tail = 6'b111111;
    #4;
    checks++; if (grant !== 6'b000100) begin failures++; $display("FAIL pkt_setup got=%b exp=%b", grant, 6'b000100); end
    next_cycle();
    req = 6'b111111;
    for (int i = 0; i < 4; i++) begin
      req_tail = et[i];
      #4;
      checks++; if (grant !== eg[i]) begin failures++; $display("FAIL pkt_grant[%0d] got=%b exp=%b", i, grant, eg[i]); end
      checks++; if (credits !== ec[i]) begin failures++; $display("FAIL pkt_credits[%0d] got=%0d exp=%0d", i, credits, ec[i]); end
      next_cycle();
    end
    req_tail = '0;
    #4;
    checks++; if (grant !== 6'b0) begin failures++; $display("FAIL pkt_nocredit got=%b exp=%b", grant, 6'b0); end
    checks++; if (credits !== 3'd0) begin failures++; $display("FAIL pkt_credits_end got=%0d exp=0", credits); end
    next_cycle();
  endtask

  task automatic test_credit_exhaust();
    do_reset();
    req = 6'b000001; req_tail = 6'b000001;
    for (int i = 0; i < 5; i++) begin
      #4;
      checks++; if (grant !== 6'b000001) begin failures++; $display("FAIL exh_grant[%0d] got=%b exp=%b", i, grant, 6'b000001); end
      checks++; if (credits !== 3'(5 - i)) begin failures++; $display("FAIL exh_credits[%0d] got=%0d exp=%0d", i, credits, 5 - i); end
      next_cycle();
    end
    #4;
    checks++; if (grant !== 6'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL exh_stall got=%b/%b exp=000000/0", grant, out_valid); end
    checks++; if (credits !== 3'd0) begin failures++; $display("FAIL exh_zero got=%0d exp=0", credits); end
    next_cycle();
    credit_in = 1'b1;
    #4;
    checks++; if (grant !== 6'b0) begin failures++; $display("FAIL exh_no_bypass got=%b exp=%b", grant, 6'b0); end
    next_cycle();
    credit_in = 1'b0;
    #4;
    checks++; if (credits !== 3'd1) begin failures++; $display("FAIL exh_return got=%0d exp=1", credits); end
    checks++; if (grant !== 6'b000001) begin failures++; $display("FAIL exh_resume got=%b exp=%b", grant, 6'b000001); end
    next_cycle();
    #4;
    checks++; if (credits !== 3'd0 || grant !== 6'b0) begin failures++; $display("FAIL exh_reempty got=%0d/%b exp=0/000000", credits, grant); end
    req = '0;
    next_cycle();
  endtask

  task automatic test_credit_simul_and_err();
    do_reset();
    req = 6'b000001; req_tail = 6'b111111;
    for (int i = 0; i < 3; i++) next_cycle();
    credit_in = 1'b1;
    #4;
    checks++; if (credits !== 3'd2 || grant !== 6'b000001) begin failures++; $display("FAIL sim_pre got=%0d/%b exp=2/000001", credits, grant); end
    next_cycle();
    req = '0; credit_in = 1'b0;
    #4;
    checks++; if (credits !== 3'd2) begin failures++; $display("FAIL sim_hold got=%0d exp=2", credits); end
    credit_in = 1'b1;
    for (int i = 0; i < 3; i++) next_cycle();
    credit_in = 1'b0;
    #4;
    checks++; if (credits !== 3'd5 || credit_err !== 1'b0) begin failures++; $display("FAIL sim_full got=%0d/%b exp=5/0", credits, credit_err); end
    credit_in = 1'b1;
    next_cycle();
    credit_in = 1'b0;
    #4;
    checks++; if (credits !== 3'd5) begin failures++; $display("FAIL err_credits got=%0d exp=5", credits); end
    checks++; if (credit_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", credit_err); end
    req = 6'b000001;
    next_cycle();
    req = '0;
    next_cycle();
    #4;
    checks++; if (credit_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", credit_err); end
    next_cycle();
  endtask

  task automatic test_lock_bubble();
    do_reset();
    req = 6'b000010; req_tail = 6'b000000;
    #4;
    checks++; if (grant !== 6'b000010) begin failures++; $display("FAIL bub_head got=%b exp=%b", grant, 6'b000010); end
    next_cycle();
    req = 6'b000100; req_tail = 6'b000100;
    for (int i = 0; i < 4; i++) begin
      #4;
      checks++; if (grant !== 6'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL bub_hold[%0d] got=%b/%b exp=000000/0", i, grant, out_valid); end
      next_cycle();
    end
    req = 6'b000110; req_tail = 6'b000010;
    #4;
    checks++; if (grant !== 6'b000010 || grant_idx !== 3'd1) begin failures++; $display("FAIL bub_tail got=%b/%0d exp=000010/1", grant, grant_idx); end
    next_cycle();
    req = 6'b000110; req_tail = 6'b000110;
    #4;
    checks++; if (grant !== 6'b000100 || grant_idx !== 3'd2) begin failures++; $display("FAIL bub_release got=%b/%0d exp=000100/2", grant, grant_idx); end
    req = '0;
    next_cycle();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    credit_in = 1'b1;
    next_cycle();
    credit_in = 1'b0;
    req = 6'b000001; req_tail = 6'b000001;
    for (int i = 0; i < 3; i++) next_cycle();
    req = 6'b000010; req_tail = 6'b000000;
    next_cycle();
    req = '0;
    #4;
    checks++; if (credits !== 3'd1 || credit_err !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0d/%b exp=1/1", credits, credit_err); end
    req = 6'b100000;
    #1;
    checks++; if (grant !== 6'b0) begin failures++; $display("FAIL mid_locked got=%b exp=%b", grant, 6'b0); end
    req = '0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #4;
    checks++; if (credits !== 3'd5 || credit_err !== 1'b0) begin failures++; $display("FAIL mid_reset got=%0d/%b exp=5/0", credits, credit_err); end
    req = 6'b100000; req_tail = 6'b000000;
    #1;
    checks++; if (grant !== 6'b100000 || grant_idx !== 3'd5 || out_valid !== 1'b1) begin failures++; $display("FAIL mid_regrant got=%b/%0d/%b exp=100000/5/1", grant, grant_idx, out_valid); end
    req = '0;
    next_cycle();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; req = '0; req_tail = '0; credit_in = 1'b0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_credit_exhaust();
    test_credit_simul_and_err();
    test_lock_bubble();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
Per-output-port controller for the router crossbar. It shares one output direction among M_IN input ports with packet-atomic round-robin arbitration. It tracks downstream buffer space with a credit counter. It drives the one-hot grant, the encoded select for the output flit mux, and the output valid strobe. One instance sits beside each of the six output-direction datapaths.

Parameters:
M_IN, 6, number of requesting input ports
CREDIT_MAX, 5, downstream buffer depth in flits; equals input_Q_size
SEL_W, 3, width of grant_idx; must be at least clog2(M_IN)
CRED_W, 3, width of credit counter; must be at least clog2(CREDIT_MAX+1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  M_IN  input i holds a valid flit routed to this output
req_tail  in  M_IN  flit on input i is the packet tail; single-flit packets assert it with the head
credit_in  in  1  one-cycle pulse, downstream freed one buffer slot
grant  out  M_IN  one-hot; input i's flit is consumed this cycle
grant_idx  out  SEL_W  binary index of granted input; 0 when no grant
out_valid  out  1  flit transferred this cycle (fire)
credits  out  CRED_W  current credit count
credit_err  out  1  sticky; a credit was returned while credits == CREDIT_MAX

Behaviour:
- Single clock clk. Reset is synchronous and active-high on rst. All state updates on rising clk.
- Reset values: state IDLE, rr_ptr 0, owner 0, credits CREDIT_MAX, credit_err 0.
- Combinational outputs evaluate to 0 during and after reset unless req is set: grant, grant_idx, out_valid.
- Define can_send = (credits != 0). A credit_in arriving in the same cycle does not enable sending; there is no bypass.
- grant, grant_idx and out_valid are combinational from the registered state and the current req. Zero-cycle latency: a flit presented with grant high is taken that cycle.
- winner = first i with req[i]=1, scanning cyclically from rr_ptr upward and wrapping M_IN-1 to 0.
- IDLE:
  - If can_send and |req: grant[winner]=1 and fire.
  - If req_tail[winner]: stay IDLE, rr_ptr <= (winner+1) mod M_IN.
  - Else: go to LOCKED, owner <= winner.
  - If no req or !can_send: no grant, state unchanged.
- LOCKED:
  - grant[owner] = req[owner] & can_send. No other input may be granted.
  - On fire with req_tail[owner]: go to IDLE, rr_ptr <= (owner+1) mod M_IN.
  - If the owner drops req mid-packet, the lock holds. Bubbles are allowed and no other input is granted.
- Credit update: credits <= credits - fire + credit_in.
  - Simultaneous fire and credit_in leaves the count unchanged.
  - credit_in at CREDIT_MAX without fire: count holds at CREDIT_MAX and credit_err <= 1. credit_err clears only on rst.
  - fire is impossible at credits == 0, so no underflow.
- out_valid = |grant. grant_idx = binary encode of grant.
- Reset mid-packet drops the lock and restores full credits. The upstream and downstream sides are reset together.
- req bits with req_tail are sampled only in the cycle they are granted.

Decomposition:
- Shared package holds:
  - state enum: IDLE=1'b0, LOCKED=1'b1
  - DIR_* direction constants and PORT_NUM
  - default CREDIT_MAX (input_Q_size)
  - clog2 helper function
- One natural sub-module: rr_priority_picker. Inputs are req and rr_ptr; outputs are the one-hot winner and its index. It is purely combinational, with a double-width mask-and-priority scheme.

Test Plan:
- Reset, then req=6'b000101, all tails set, credits 5 → cycle 1 grant=000001, idx 0; cycle 2 grant=000100, idx 2; cycle 3 grant=000001; credits drop 5→4→3→2.
- Input 3 sends a 3-flit packet (tail on 3rd flit) while req=6'b111111 throughout → grant=001000 for 3 consecutive cycles, then grant=010000 (rr_ptr=4).
- No credit_in, input 0 streams single-flit packets → exactly 5 grants, then grant=0 with credits=0. One credit_in pulse → credits=1, next cycle one grant, credits back to 0.
- credits=2, fire and credit_in in the same cycle → credits stays 2. credit_in at credits=5 with no fire → credits=5, credit_err=1 and stays 1.
- Input 1 is LOCKED after its head flit, then drops req for 4 cycles while input 2 requests → grant=0 for those cycles. When input 1 reasserts with tail → grant=000010, then IDLE.
- rst asserted mid-packet (LOCKED, credits=1) → next cycle state IDLE, credits=5, rr_ptr=0, credit_err=0. req=6'b100000 is granted immediately.
